// File: rtl/exp_request_ctrl.sv
// Exception-source request controller: synchronises, debounces and edge-detects raw
// event lines, latches them as pending, and issues one prioritised request at a time to the CPU.
`timescale 1ns/1ps
module exp_request_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             pc_clk,
  input  logic             reset,
  input  logic [2:0]       evt_in,
  input  logic [2:0]       mask,
  input  logic             hasexp,
  input  logic             eret_done,
  output logic [2:0]       expsrc,
  output logic             busy,
  output logic [1:0]       active_src,
  output logic [2:0]       pending,
  output logic [CNT_W-1:0] dropped_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [2:0] clean;
  logic [2:0] clean_d_reg;
  logic [2:0] rise;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [7:0]             deb_cnt_reg;
      logic                   clean_bit_reg;
      logic                   sync_out;

      assign sync_out  = sync_reg[SYNC_STAGES-1];
      assign clean[gi] = clean_bit_reg;

      // A level change is accepted only after DEB_CYCLES consecutive differing samples.
      always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
          sync_reg      <= '0;
          deb_cnt_reg   <= '0;
          clean_bit_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], evt_in[gi]};
          if (sync_out == clean_bit_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == 8'(DEB_CYCLES - 1)) begin
            clean_bit_reg <= sync_out;
            deb_cnt_reg   <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 8'd1;
          end
        end
      end
    end
  endgenerate

  assign rise = clean & ~clean_d_reg;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       expsrc_next;
  logic [1:0]       active_next;
  logic [2:0]       clr;
  logic [2:0]       avail;
  logic [1:0]       sel;
  logic [2:0]       pending_next;
  logic [2:0]       drop_vec;
  logic [1:0]       drop_num;
  logic [CNT_W+1:0] drop_sum;
  logic [CNT_W-1:0] dropped_next;

  assign avail = pending & mask;
  assign sel   = avail[0] ? 2'd0 : (avail[1] ? 2'd1 : 2'd2);
  assign busy  = (state_reg != IDLE);

  always_comb begin
    state_next  = state_reg;
    expsrc_next = expsrc;
    active_next = active_src;
    clr         = 3'b000;
    case (state_reg)
      IDLE: begin
        if (avail != 3'b000) begin
          state_next  = REQ;
          active_next = sel;
          expsrc_next = 3'b001 << sel;
        end
      end
      REQ: begin
        // Acknowledge wins over withdrawal; eret_done has no meaning here.
        if (hasexp) begin
          clr         = 3'b001 << active_src;
          expsrc_next = 3'b000;
          state_next  = SERVICE;
        end else if (!mask[active_src]) begin
          expsrc_next = 3'b000;
          active_next = 2'd0;
          state_next  = IDLE;
        end
      end
      SERVICE: begin
        expsrc_next = 3'b000;
        if (eret_done) begin
          active_next = 2'd0;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        expsrc_next = 3'b000;
        active_next = 2'd0;
      end
    endcase
  end

  // A new event on an already-pending source is counted as lost; set beats clear.
  assign drop_vec     = rise & pending;
  assign drop_num     = {1'b0, drop_vec[0]} + {1'b0, drop_vec[1]} + {1'b0, drop_vec[2]};
  assign drop_sum     = {2'b00, dropped_cnt} + (CNT_W+2)'(drop_num);
  assign dropped_next = (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : drop_sum[CNT_W-1:0];
  assign pending_next = (pending & ~clr) | rise;

  always_ff @(posedge pc_clk or posedge reset) begin
    if (reset) begin
      clean_d_reg <= 3'b000;
      state_reg   <= IDLE;
      expsrc      <= 3'b000;
      active_src  <= 2'd0;
      pending     <= 3'b000;
      dropped_cnt <= '0;
    end else begin
      clean_d_reg <= clean;
      state_reg   <= state_next;
      expsrc      <= expsrc_next;
      active_src  <= active_next;
      pending     <= pending_next;
      dropped_cnt <= dropped_next;
    end
  end

endmodule

// File: tb/tb_exp_request_ctrl.sv
// Directed self-checking bench for exp_request_ctrl; a second instance with a 2-bit
// drop counter exercises saturation.
`timescale 1ns/1ps
module tb_exp_request_ctrl;

  logic       pc_clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] evt_in = 3'b000;
  logic [2:0] mask = 3'b111;
  logic       hasexp = 1'b0;
  logic       eret_done = 1'b0;
  logic [2:0] expsrc;
  logic       busy;
  logic [1:0] active_src;
  logic [2:0] pending;
  logic [7:0] dropped_cnt;

  logic [2:0] evt2 = 3'b000;
  logic [2:0] mask2 = 3'b000;
  logic       hasexp2 = 1'b0;
  logic       eret2 = 1'b0;
  logic [2:0] expsrc2;
  logic       busy2;
  logic [1:0] active2;
  logic [2:0] pending2;
  logic [1:0] dropped2;

  int tests = 0;
  int fails = 0;

  always #5 pc_clk = ~pc_clk;

  exp_request_ctrl #(.SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(8)) dut (
    .pc_clk(pc_clk), .reset(reset), .evt_in(evt_in), .mask(mask),
    .hasexp(hasexp), .eret_done(eret_done), .expsrc(expsrc), .busy(busy),
    .active_src(active_src), .pending(pending), .dropped_cnt(dropped_cnt)
  );

  exp_request_ctrl #(.SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(2)) dut2 (
    .pc_clk(pc_clk), .reset(reset), .evt_in(evt2), .mask(mask2),
    .hasexp(hasexp2), .eret_done(eret2), .expsrc(expsrc2), .busy(busy2),
    .active_src(active2), .pending(pending2), .dropped_cnt(dropped2)
  );

  task automatic tick();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    evt_in = 3'b000; mask = 3'b111; hasexp = 1'b0; eret_done = 1'b0;
    evt2 = 3'b000; mask2 = 3'b000;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  // High for 6 sampled edges (accepted), then low long enough for the clean level to fall.
  task automatic pulse(input bit on2, input int src);
    if (on2) evt2[src] = 1'b1; else evt_in[src] = 1'b1;
    ticks(6);
    if (on2) evt2[src] = 1'b0; else evt_in[src] = 1'b0;
    ticks(8);
  endtask

  task automatic test_reset();
    #2;
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL rst_expsrc: got %b expected 000", expsrc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tests++; if (pending !== 3'b000) begin fails++; $display("FAIL rst_pending: got %b expected 000", pending); end
    tests++; if (dropped_cnt !== 8'd0) begin fails++; $display("FAIL rst_dropped: got %0d expected 0", dropped_cnt); end
    tests++; if (active_src !== 2'd0) begin fails++; $display("FAIL rst_active: got %0d expected 0", active_src); end
    apply_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_reset_mid_req();
    apply_reset();
    evt_in = 3'b001;
    ticks(10);
    tests++; if (expsrc !== 3'b001) begin fails++; $display("FAIL midreq_pre_expsrc: got %b expected 001", expsrc); end
    #2 reset = 1'b1;
    #1;
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL midreq_expsrc: got %b expected 000", expsrc); end
    tests++; if (pending !== 3'b000) begin fails++; $display("FAIL midreq_pending: got %b expected 000", pending); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreq_busy: got %b expected 0", busy); end
    tests++; if (dropped_cnt !== 8'd0) begin fails++; $display("FAIL midreq_dropped: got %0d expected 0", dropped_cnt); end
    evt_in = 3'b000;
    tick();
    reset = 1'b0;
    ticks(3);
    tests++; if (busy !== 1'b0 || expsrc !== 3'b000) begin fails++; $display("FAIL midreq_idle: got busy=%b expsrc=%b expected 0/000", busy, expsrc); end
    $display("[TB] test_reset_mid_req done");
  endtask

  task automatic test_debounce();
    apply_reset();
    evt_in[1] = 1'b1;
    ticks(3);
    evt_in[1] = 1'b0;
    ticks(10);
    tests++; if (pending !== 3'b000) begin fails++; $display("FAIL glitch_pending: got %b expected 000", pending); end
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL glitch_expsrc: got %b expected 000", expsrc); end
    evt_in[1] = 1'b1;
    ticks(7);
    tests++; if (pending !== 3'b010) begin fails++; $display("FAIL deb_pending: got %b expected 010", pending); end
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL deb_expsrc_early: got %b expected 000", expsrc); end
    tick();
    tests++; if (expsrc !== 3'b010) begin fails++; $display("FAIL deb_expsrc: got %b expected 010", expsrc); end
    evt_in = 3'b000;
    $display("[TB] test_debounce done");
  endtask

  task automatic test_priority();
    apply_reset();
    evt_in = 3'b110;
    ticks(8);
    evt_in = 3'b000;
    tests++; if (expsrc !== 3'b010) begin fails++; $display("FAIL prio_first: got %b expected 010", expsrc); end
    tests++; if (active_src !== 2'd1) begin fails++; $display("FAIL prio_active1: got %0d expected 1", active_src); end
    hasexp = 1'b1; tick(); hasexp = 1'b0;
    tests++; if (pending !== 3'b100) begin fails++; $display("FAIL prio_pending: got %b expected 100", pending); end
    eret_done = 1'b1; tick(); eret_done = 1'b0;
    tests++; if (busy !== 1'b0 || expsrc !== 3'b000) begin fails++; $display("FAIL prio_gap: got busy=%b expsrc=%b expected 0/000", busy, expsrc); end
    tick();
    tests++; if (expsrc !== 3'b100) begin fails++; $display("FAIL prio_second: got %b expected 100", expsrc); end
    tests++; if (active_src !== 2'd2) begin fails++; $display("FAIL prio_active2: got %0d expected 2", active_src); end
    $display("[TB] test_priority done");
  endtask

  task automatic test_handshake();
    bit held;
    apply_reset();
    evt_in = 3'b001;
    ticks(8);
    evt_in = 3'b000;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (expsrc !== 3'b001) held = 1'b0;
    end
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL hs_hold: got expsrc=%b expected 001 for 20 cycles", expsrc); end
    hasexp = 1'b1; tick(); hasexp = 1'b0;
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL hs_expsrc: got %b expected 000", expsrc); end
    tests++; if (pending[0] !== 1'b0) begin fails++; $display("FAIL hs_pending0: got %b expected 0", pending[0]); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hs_busy: got %b expected 1", busy); end
    eret_done = 1'b1; tick(); eret_done = 1'b0;
    tests++; if (busy !== 1'b0 || active_src !== 2'd0) begin fails++; $display("FAIL hs_eret: got busy=%b active=%0d expected 0/0", busy, active_src); end
    $display("[TB] test_handshake done");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    evt_in = 3'b001;
    ticks(8);
    evt_in = 3'b000;
    hasexp = 1'b1; eret_done = 1'b1; tick(); hasexp = 1'b0; eret_done = 1'b0;
    tests++; if (busy !== 1'b1 || expsrc !== 3'b000) begin fails++; $display("FAIL sim_service: got busy=%b expsrc=%b expected 1/000", busy, expsrc); end
    ticks(2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sim_stay: got busy=%b expected 1", busy); end
    eret_done = 1'b1; tick(); eret_done = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sim_eret: got busy=%b expected 0", busy); end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_drop_count();
    apply_reset();
    evt_in = 3'b001;
    ticks(8);
    evt_in = 3'b000;
    hasexp = 1'b1; tick(); hasexp = 1'b0;
    for (int k = 0; k < 3; k++) pulse(1'b0, 2);
    tests++; if (pending !== 3'b100) begin fails++; $display("FAIL drop_pending: got %b expected 100", pending); end
    tests++; if (dropped_cnt !== 8'd2) begin fails++; $display("FAIL drop_cnt: got %0d expected 2", dropped_cnt); end
    tests++; if (busy !== 1'b1 || expsrc !== 3'b000) begin fails++; $display("FAIL drop_service: got busy=%b expsrc=%b expected 1/000", busy, expsrc); end
    eret_done = 1'b1; tick(); eret_done = 1'b0;
    tick();
    tests++; if (expsrc !== 3'b100) begin fails++; $display("FAIL drop_issue: got %b expected 100", expsrc); end
    $display("[TB] test_drop_count done");
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int k = 0; k < 3; k++) pulse(1'b1, 0);
    tests++; if (dropped2 !== 2'd2) begin fails++; $display("FAIL sat_mid: got %0d expected 2", dropped2); end
    tests++; if (pending2 !== 3'b001) begin fails++; $display("FAIL sat_pending: got %b expected 001", pending2); end
    for (int k = 0; k < 3; k++) pulse(1'b1, 0);
    tests++; if (dropped2 !== 2'd3) begin fails++; $display("FAIL sat_cap: got %0d expected 3", dropped2); end
    $display("[TB] test_saturate done");
  endtask

  task automatic test_mask_withdraw();
    apply_reset();
    evt_in = 3'b001;
    ticks(8);
    evt_in = 3'b000;
    tests++; if (expsrc !== 3'b001) begin fails++; $display("FAIL mw_req: got %b expected 001", expsrc); end
    mask = 3'b110; tick();
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL mw_expsrc: got %b expected 000", expsrc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mw_idle: got busy=%b expected 0", busy); end
    tests++; if (pending !== 3'b001) begin fails++; $display("FAIL mw_pending: got %b expected 001", pending); end
    tick();
    tests++; if (expsrc !== 3'b000) begin fails++; $display("FAIL mw_masked: got %b expected 000", expsrc); end
    mask = 3'b111; tick();
    tests++; if (expsrc !== 3'b001) begin fails++; $display("FAIL mw_reissue: got %b expected 001", expsrc); end
    $display("[TB] test_mask_withdraw done");
  endtask

  initial begin
    test_reset();
    test_reset_mid_req();
    test_debounce();
    test_priority();
    test_handshake();
    test_simultaneous();
    test_drop_count();
    test_saturate();
    test_mask_withdraw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exp_request_ctrl.md
Name: exp_request_ctrl

Overview:
- Initiator side of the CPU exception-source interface: turns raw external event lines (buttons/peripheral strobes) into clean, prioritised, one-at-a-time requests on expsrc[2:0].
- Holds a request until the CPU signals exception entry (hasexp).
- Blocks further requests until the handler returns (eret).
- Sits between board I/O and the CPU top level, clocked by the CPU PC clock.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- DEB_CYCLES, 4, consecutive identical synchronised samples required before the clean level changes (range 1..255).
- CNT_W, 8, width of the dropped-event counter.

Ports:
- pc_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- evt_in  input  3  raw asynchronous event lines; bit i is source i.
- mask  input  3  per-source enable; 1 = source may be issued.
- hasexp  input  1  CPU has entered an exception (acknowledge); level, sampled.
- eret_done  input  1  CPU executed eret (iseret & iscop0); level, sampled.
- expsrc  output  3  one-hot request to the CPU; registered.
- busy  output  1  1 when the FSM is not IDLE.
- active_src  output  2  index of the source being requested/serviced; 0 when IDLE.
- pending  output  3  latched, not-yet-issued events.
- dropped_cnt  output  CNT_W  events lost because the source was already pending; saturating.

Behaviour:
- Reset (async, active-high): all of the following go to 0 immediately.
  - Synchronisers, debounce counters, clean levels, pending, dropped_cnt.
  - expsrc, busy, active_src; FSM to IDLE.
- Synchroniser: evt_in[i] passes through SYNC_STAGES flip-flops. Only the last stage's output is used.
- Debounce, per source:
  - If sync == clean, the counter resets to 0.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, clean <= sync on that edge and the counter resets.
  - Net effect: a level change is accepted after DEB_CYCLES consecutive differing samples.
- Edge detect: a clean 0->1 transition is an event. Falling edges are ignored.
- Pending update on an event for source i:
  - If pending[i] is 0, set pending[i] (mask is irrelevant here).
  - If pending[i] is already 1, leave it set and increment dropped_cnt, saturating at all-ones.
  - Set wins over the clear in the same cycle.
- FSM states:
  - IDLE: if (pending & mask) != 0, select the lowest set index (source 0 highest priority). On that edge go to REQ, load active_src, and set the expsrc one-hot bit.
  - REQ: expsrc held.
    - If hasexp=1: clear pending[active_src], expsrc <= 0, go to SERVICE.
    - Else if mask[active_src] falls to 0: withdraw. expsrc <= 0, pending kept, go to IDLE.
    - eret_done is ignored in REQ.
  - SERVICE: expsrc = 0. New events still latch into pending but are not issued. If eret_done=1, go to IDLE and clear active_src to 0.
- Re-issue: from IDLE, the next request is issued no earlier than one cycle after the SERVICE->IDLE transition.
- Latency:
  - evt_in rise to clean rise: SYNC_STAGES + DEB_CYCLES edges.
  - Clean rise to pending: 1 edge.
  - Pending to expsrc: 1 edge.
- expsrc is always one-hot or zero, never multi-hot. busy = (state != IDLE).
- Simultaneous hasexp and eret_done in REQ: hasexp is taken. eret_done is ignored, so the FSM stays in SERVICE until a later eret_done.
- Mask change while pending: a masked pending bit is kept and issued when unmasked.

Test Plan:
- Reset mid-REQ: drive evt_in=001 held 10 cycles, then assert reset while expsrc=001. Required: expsrc, pending, busy and dropped_cnt all 0 on the same edge; FSM IDLE after release.
- Debounce glitch, DEB_CYCLES=4: evt_in[1] high for 3 cycles then low. Required: pending stays 000 and expsrc 000. Held 4+ cycles: pending[1]=1, then expsrc=010 one edge later.
- Priority: evt_in=110 simultaneous, mask=111. Required: expsrc=010 first. hasexp, then eret_done. Next: expsrc=100, active_src=2.
- Handshake: in REQ, hold hasexp low 20 cycles. Required: expsrc stays 001. hasexp=1: next edge expsrc=000, pending[0]=0, busy=1. eret_done=1: busy=0.
- Drop count: during SERVICE, pulse source 2 three separate debounced times. Required: pending[2]=1, dropped_cnt=2. With CNT_W=2 and 5 drops: dropped_cnt saturates at 3.
- Mask withdraw: in REQ for source 0, clear mask[0]. Required: next edge expsrc=000, IDLE, pending[0]=1. Re-set mask[0]: expsrc=001 again.
